// File: rtl/tib_loader.sv
// tib_loader: line assembler feeding the terminal input buffer.
// Accepts a byte stream, applies backspace editing and overflow dropping,
// writes the line plus a 0 terminator at TIB, then holds go until done.
// Optional build macro: TIB_LOADER_ECHO_EN adds a tx echo channel (state ECH).
//
// state | meaning
// IDL   | waiting for an input byte (rx_ready=1)
// WR    | writing accepted character at TIB+ptr
// TRM   | writing 0 terminator at TIB+ptr
// RUN   | line ready, go=1, waiting for done
// ECH   | sending echo bytes on tx (echo build only)
module tib_loader #(
    parameter int TIB    = 'h0,
    parameter int TIB_SZ = 80,
    parameter int ASZ    = 17,
    parameter int MSZ    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [MSZ-1:0] rx_data,
    output logic           rx_ready,
    output logic           we,
    output logic [ASZ-1:0] ai,
    output logic [MSZ-1:0] vi,
    output logic           go,
    input  logic           done,
    output logic           ovf
`ifdef TIB_LOADER_ECHO_EN
    ,
    output logic           tx_valid,
    output logic [MSZ-1:0] tx_data,
    input  logic           tx_ready
`endif
);

    localparam int PW = $clog2(TIB_SZ);
    localparam logic [PW-1:0] LAST = PW'(TIB_SZ - 1);

    typedef enum logic [2:0] {IDL, WR, TRM, RUN, ECH} st_t;

    st_t            st, nst;
    logic [PW-1:0]  ptr, nptr;
    logic [MSZ-1:0] c, nc;
    logic [MSZ-1:0] b;
    logic           nrdy, nwe, ngo, novf;
    logic [ASZ-1:0] nai;
    logic [MSZ-1:0] nvi;

`ifdef TIB_LOADER_ECHO_EN
    localparam logic [1:0] K_CHR = 2'd0, K_BS = 2'd1, K_TRM = 2'd2;
    logic [1:0]     kind, nkind, idx, nidx;
    logic           ntxv;
    logic [MSZ-1:0] ntxd;

    function automatic logic [MSZ-1:0] echo_byte(input logic [1:0] k, input logic [1:0] i,
                                                 input logic [MSZ-1:0] ch);
        case (k)
            K_BS:    echo_byte = (i == 2'd1) ? MSZ'(8'h20) : MSZ'(8'h08);
            K_TRM:   echo_byte = (i == 2'd0) ? MSZ'(8'h0D) : MSZ'(8'h0A);
            default: echo_byte = ch;
        endcase
    endfunction

    function automatic logic echo_last(input logic [1:0] k, input logic [1:0] i);
        case (k)
            K_BS:    echo_last = (i == 2'd2);
            K_TRM:   echo_last = (i == 2'd1);
            default: echo_last = 1'b1;
        endcase
    endfunction
`endif

    // Next-state and next registered output values.
    always_comb begin
        nst  = st;
        nptr = ptr;
        nc   = c;
        nrdy = 1'b0;
        nwe  = 1'b0;
        ngo  = 1'b0;
        novf = ovf;
        nai  = ai;
        nvi  = vi;
        b    = (rx_data == MSZ'(8'h09)) ? MSZ'(8'h20) : rx_data;
`ifdef TIB_LOADER_ECHO_EN
        nkind = kind;
        nidx  = idx;
        ntxv  = tx_valid;
        ntxd  = tx_data;
`endif
        case (st)
            IDL: begin
                nrdy = 1'b1;
                if (rx_valid) begin
                    if (b >= MSZ'(8'h20) && b <= MSZ'(8'h7E)) begin
                        if (ptr < LAST) begin
                            nst  = WR;
                            nc   = b;
                            nwe  = 1'b1;
                            nai  = ASZ'(TIB) + ASZ'(ptr);
                            nvi  = b;
                            nrdy = 1'b0;
                        end else begin
                            novf = 1'b1;
                        end
                    end else if (b == MSZ'(8'h08) || b == MSZ'(8'h7F)) begin
                        if (ptr != '0) begin
                            nptr = ptr - 1'b1;
`ifdef TIB_LOADER_ECHO_EN
                            nst   = ECH;
                            nkind = K_BS;
                            nidx  = 2'd0;
                            ntxv  = 1'b1;
                            ntxd  = MSZ'(8'h08);
                            nrdy  = 1'b0;
`endif
                        end
                    end else if (b == MSZ'(8'h0D) || b == MSZ'(8'h0A)) begin
                        if (ptr != '0) begin
                            nst  = TRM;
                            nwe  = 1'b1;
                            nai  = ASZ'(TIB) + ASZ'(ptr);
                            nvi  = '0;
                            nrdy = 1'b0;
                        end
                    end
                end
            end
            WR: begin
                nptr = ptr + 1'b1;
`ifdef TIB_LOADER_ECHO_EN
                nst   = ECH;
                nkind = K_CHR;
                nidx  = 2'd0;
                ntxv  = 1'b1;
                ntxd  = c;
`else
                nst  = IDL;
                nrdy = 1'b1;
`endif
            end
            TRM: begin
`ifdef TIB_LOADER_ECHO_EN
                nst   = ECH;
                nkind = K_TRM;
                nidx  = 2'd0;
                ntxv  = 1'b1;
                ntxd  = MSZ'(8'h0D);
`else
                nst = RUN;
                ngo = 1'b1;
`endif
            end
            RUN: begin
                if (done) begin
                    nst  = IDL;
                    nptr = '0;
                    novf = 1'b0;
                    nrdy = 1'b1;
                end else begin
                    ngo = 1'b1;
                end
            end
`ifdef TIB_LOADER_ECHO_EN
            ECH: begin
                if (tx_ready) begin
                    if (echo_last(kind, idx)) begin
                        ntxv = 1'b0;
                        if (kind == K_TRM) begin
                            nst = RUN;
                            ngo = 1'b1;
                        end else begin
                            nst  = IDL;
                            nrdy = 1'b1;
                        end
                    end else begin
                        nidx = idx + 2'd1;
                        ntxd = echo_byte(kind, idx + 2'd1, c);
                    end
                end
            end
`endif
            default: nst = IDL;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDL;
            ptr      <= '0;
            c        <= '0;
            rx_ready <= 1'b0;
            we       <= 1'b0;
            ai       <= ASZ'(TIB);
            vi       <= '0;
            go       <= 1'b0;
            ovf      <= 1'b0;
`ifdef TIB_LOADER_ECHO_EN
            kind     <= K_CHR;
            idx      <= 2'd0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
`endif
        end else begin
            st       <= nst;
            ptr      <= nptr;
            c        <= nc;
            rx_ready <= nrdy;
            we       <= nwe;
            ai       <= nai;
            vi       <= nvi;
            go       <= ngo;
            ovf      <= novf;
`ifdef TIB_LOADER_ECHO_EN
            kind     <= nkind;
            idx      <= nidx;
            tx_valid <= ntxv;
            tx_data  <= ntxd;
`endif
        end
    end

endmodule

// File: tb/tb_tib_loader.sv
// tb_tib_loader: scoreboard bench for tib_loader; expected memory writes are
// queued as bytes are sent and popped when the DUT strobes we.
module tb_tib_loader;

    localparam int TIB    = 'h0;
    localparam int TIB_SZ = 80;
    localparam int ASZ    = 17;
    localparam int MSZ    = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx_valid = 1'b0;
    logic [MSZ-1:0] rx_data = '0;
    logic           rx_ready;
    logic           we;
    logic [ASZ-1:0] ai;
    logic [MSZ-1:0] vi;
    logic           go;
    logic           done = 1'b0;
    logic           ovf;
`ifdef TIB_LOADER_ECHO_EN
    logic           tx_valid;
    logic [MSZ-1:0] tx_data;
    logic           tx_ready = 1'b1;
    logic [MSZ-1:0] txq[$];
`endif

    int total = 0;
    int bad   = 0;

    logic [ASZ+MSZ-1:0] wq[$];
    int   mptr = 0;
    logic movf = 1'b0;
    logic line_pending = 1'b0;
    logic mon_en = 1'b1;

    tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .ASZ(ASZ), .MSZ(MSZ)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .we(we), .ai(ai), .vi(vi), .go(go),
        .done(done), .ovf(ovf)
`ifdef TIB_LOADER_ECHO_EN
        , .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
`endif
    );

    always #5 clk = ~clk;

    // Write monitor: every we strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (we && go) begin
                total++; bad++;
                $display("FAIL we_go_overlap: we=%0b go=%0b required not both 1", we, go);
            end
            if (we) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: ai=%0h vi=%0h required no write", ai, vi);
                end else begin
                    logic [ASZ+MSZ-1:0] e;
                    e = wq.pop_front();
                    if ({ai, vi} !== e) begin
                        bad++;
                        $display("FAIL write: ai=%0h vi=%0h required ai=%0h vi=%0h",
                                 ai, vi, e[ASZ+MSZ-1:MSZ], e[MSZ-1:0]);
                    end
                end
            end
`ifdef TIB_LOADER_ECHO_EN
            if (tx_valid && tx_ready) begin
                total++;
                if (txq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_echo: tx_data=%0h required none", tx_data);
                end else begin
                    logic [MSZ-1:0] t;
                    t = txq.pop_front();
                    if (tx_data !== t) begin
                        bad++;
                        $display("FAIL echo: tx_data=%0h required %0h", tx_data, t);
                    end
                end
            end
`endif
        end
    end

    // Apply model, push expectations, perform handshake, check write latency.
    task automatic send_char(input logic [MSZ-1:0] ch);
        logic [MSZ-1:0] b2;
        logic exp_we;
        int n;
        b2 = (ch == 8'h09) ? 8'h20 : ch;
        exp_we = 1'b0;
        if (b2 >= 8'h20 && b2 <= 8'h7E) begin
            if (mptr < TIB_SZ - 1) begin
                wq.push_back({ASZ'(TIB + mptr), b2});
`ifdef TIB_LOADER_ECHO_EN
                txq.push_back(b2);
`endif
                mptr++;
                exp_we = 1'b1;
            end else begin
                movf = 1'b1;
            end
        end else if (b2 == 8'h08 || b2 == 8'h7F) begin
            if (mptr > 0) begin
                mptr--;
`ifdef TIB_LOADER_ECHO_EN
                txq.push_back(8'h08); txq.push_back(8'h20); txq.push_back(8'h08);
`endif
            end
        end else if (b2 == 8'h0D || b2 == 8'h0A) begin
            if (mptr > 0) begin
                wq.push_back({ASZ'(TIB + mptr), 8'h00});
`ifdef TIB_LOADER_ECHO_EN
                txq.push_back(8'h0D); txq.push_back(8'h0A);
`endif
                exp_we = 1'b1;
                line_pending = 1'b1;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = ch;
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL rx_timeout: rx_ready=%0b required 1 within 100 cycles", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (we !== exp_we) begin
            bad++;
            $display("FAIL we_latency: byte=%0h we=%0b required %0b", ch, we, exp_we);
        end
    endtask

    // Wait for go, check ovf, pulse done and check rearm.
    task automatic finish_line();
        int n;
        n = 0;
        while (go !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (go !== 1'b1) begin
            bad++;
            $display("FAIL go_wait: go=%0b required 1", go);
        end
        repeat (3) @(negedge clk);
        total++;
        if (go !== 1'b1 || rx_ready !== 1'b0 || ovf !== movf) begin
            bad++;
            $display("FAIL run_hold: go=%0b rx_ready=%0b ovf=%0b required 1 0 %0b",
                     go, rx_ready, ovf, movf);
        end
        total++;
        if (wq.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: pending=%0d required 0", wq.size());
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++;
        if (go !== 1'b0 || rx_ready !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL rearm: go=%0b rx_ready=%0b ovf=%0b required 0 1 0", go, rx_ready, ovf);
        end
        mptr = 0;
        movf = 1'b0;
        line_pending = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (rx_ready !== 1'b0 || we !== 1'b0 || ai !== ASZ'(TIB) || vi !== '0 ||
            go !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset: rdy=%0b we=%0b ai=%0h vi=%0h go=%0b ovf=%0b required 0 0 %0h 0 0 0",
                     rx_ready, we, ai, vi, go, ovf, TIB);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready: rx_ready=%0b required 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        send_str("2 3 +");
        send_char(8'h0D);
        finish_line();
    endtask

    task automatic test_backspace();
        send_char(8'h08);
        send_str("ab");
        send_char(8'h08);
        send_str("c");
        send_char(8'h7F);
        send_char(8'h7F);
        send_char(8'h7F);
        send_str("a");
        send_char(8'h09);
        send_str("c");
        send_char(8'h01);
        send_char(8'h0A);
        finish_line();
    endtask

    task automatic test_blank();
        send_char(8'h0D);
        send_char(8'h0A);
        send_char(8'h0D);
        repeat (4) @(negedge clk);
        total++;
        if (go !== 1'b0 || rx_ready !== 1'b1 || wq.size() != 0) begin
            bad++;
            $display("FAIL blank: go=%0b rx_ready=%0b pending=%0d required 0 1 0",
                     go, rx_ready, wq.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 85; i++) send_char("x");
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: ovf=%0b required 1", ovf);
        end
        send_char(8'h08);
        send_str("y");
        send_char(8'h0D);
        finish_line();
    endtask

    task automatic test_rst_midline();
        send_str("abc");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (we !== 1'b0 || go !== 1'b0 || rx_ready !== 1'b0 || ai !== ASZ'(TIB)) begin
            bad++;
            $display("FAIL rst_mid: we=%0b go=%0b rdy=%0b ai=%0h required 0 0 0 %0h",
                     we, go, rx_ready, ai, TIB);
        end
        rst = 1'b0;
        mptr = 0;
        movf = 1'b0;
        @(negedge clk);
        send_str("d");
        send_char(8'h0D);
        finish_line();
    endtask

    task automatic test_back_to_back();
        send_str("ok");
        send_char(8'h0D);
        finish_line();
        send_str("z");
        send_char(8'h0A);
        finish_line();
    endtask

`ifdef TIB_LOADER_ECHO_EN
    task automatic test_echo();
        tx_ready = 1'b0;
        send_str("a");
        repeat (5) @(negedge clk);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h61 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL echo_stall: tx_valid=%0b tx_data=%0h rdy=%0b required 1 61 0",
                     tx_valid, tx_data, rx_ready);
        end
        tx_ready = 1'b1;
        send_char(8'h08);
        send_str("b");
        send_char(8'h0D);
        finish_line();
        total++;
        if (txq.size() != 0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL echo_drain: pending=%0d tx_valid=%0b required 0 0", txq.size(), tx_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backspace();
        test_blank();
        test_overflow();
        test_rst_midline();
        test_back_to_back();
`ifdef TIB_LOADER_ECHO_EN
        test_echo();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
